// File: rtl/muldiv_unit_if.sv
// Issue and result handshake between the execute stage and muldiv_unit.
interface muldiv_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        div_by_zero;

  modport master (
    output in_valid, op, operand1, operand2, flush, out_ready,
    input  in_ready, out_valid, result, div_by_zero
  );

  modport slave (
    input  in_valid, op, operand1, operand2, flush, out_ready,
    output in_ready, out_valid, result, div_by_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on magnitudes, with sign correction applied in a single FIX cycle.
module muldiv_unit (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

  state_t      state_r;
  logic [2:0]  op_r;
  logic        sign1_r, sign2_r;
  logic [31:0] mag_r;      // multiplicand magnitude, or divisor magnitude
  logic [63:0] acc_r;      // {hi,lo} product, or {remainder,dividend/quotient}
  logic [4:0]  cnt_r;
  logic [31:0] result_r;
  logic        dbz_r;
  logic        out_valid_r;

  logic        sign1_s, sign2_s;
  logic [31:0] abs1_s, abs2_s;
  logic        special_s, special_dbz_s;
  logic [31:0] special_res_s;
  logic [32:0] mul_sum_s, shifted_s;
  logic [31:0] diff_s;
  logic [63:0] mul_next_s, div_next_s, prod_s;
  logic [31:0] fix_res_s;

  assign bus.in_ready    = (state_r == IDLE);
  assign bus.out_valid   = out_valid_r;
  assign bus.result      = result_r;
  assign bus.div_by_zero = dbz_r;

  // Operand signedness, magnitudes and early-out detection at acceptance.
  always_comb begin
    sign1_s = 1'b0;
    sign2_s = 1'b0;
    case (bus.op)
      3'b001, 3'b100, 3'b110: begin
        sign1_s = bus.operand1[31];
        sign2_s = bus.operand2[31];
      end
      3'b010: begin
        sign1_s = bus.operand1[31];
        sign2_s = 1'b0;
      end
      default: begin
        sign1_s = 1'b0;
        sign2_s = 1'b0;
      end
    endcase
    abs1_s = sign1_s ? (32'd0 - bus.operand1) : bus.operand1;
    abs2_s = sign2_s ? (32'd0 - bus.operand2) : bus.operand2;

    special_s     = 1'b0;
    special_dbz_s = 1'b0;
    special_res_s = 32'd0;
    if (bus.op[2] && (bus.operand2 == 32'd0)) begin
      special_s     = 1'b1;
      special_dbz_s = 1'b1;
      special_res_s = bus.op[1] ? bus.operand1 : 32'hFFFF_FFFF;
    end else if (bus.op[2] && !bus.op[0] && (bus.operand1 == 32'h8000_0000) &&
                 (bus.operand2 == 32'hFFFF_FFFF)) begin
      special_s     = 1'b1;
      special_res_s = bus.op[1] ? 32'd0 : 32'h8000_0000;
    end else begin
      special_s     = 1'b0;
      special_dbz_s = 1'b0;
      special_res_s = 32'd0;
    end
  end

  // One-bit-per-cycle step for both datapaths; the remainder is shifted into 33 bits
  // so divisors above 2^31 compare correctly.
  always_comb begin
    mul_sum_s  = {1'b0, acc_r[63:32]} + {1'b0, mag_r};
    mul_next_s = acc_r[0] ? {mul_sum_s, acc_r[31:1]} : {1'b0, acc_r[63:1]};
    shifted_s  = {acc_r[63:32], acc_r[31]};
    diff_s     = shifted_s[31:0] - mag_r;
    if (shifted_s >= {1'b0, mag_r}) begin
      div_next_s = {diff_s, acc_r[30:0], 1'b1};
    end else begin
      div_next_s = {shifted_s[31:0], acc_r[30:0], 1'b0};
    end
  end

  // Sign correction and result selection.
  always_comb begin
    prod_s = (sign1_r ^ sign2_r) ? (64'd0 - acc_r) : acc_r;
    case (op_r)
      3'b000:                 fix_res_s = prod_s[31:0];
      3'b001, 3'b010, 3'b011: fix_res_s = prod_s[63:32];
      3'b100, 3'b101:         fix_res_s = (sign1_r ^ sign2_r) ? (32'd0 - acc_r[31:0]) : acc_r[31:0];
      3'b110, 3'b111:         fix_res_s = sign1_r ? (32'd0 - acc_r[63:32]) : acc_r[63:32];
      default:                fix_res_s = 32'd0;
    endcase
  end

  // Control FSM with registered outputs; out_valid rises one cycle after entering DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      op_r        <= 3'd0;
      sign1_r     <= 1'b0;
      sign2_r     <= 1'b0;
      mag_r       <= 32'd0;
      acc_r       <= 64'd0;
      cnt_r       <= 5'd0;
      result_r    <= 32'd0;
      dbz_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (bus.flush) begin
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          out_valid_r <= 1'b0;
          if (bus.in_valid) begin
            op_r    <= bus.op;
            sign1_r <= sign1_s;
            sign2_r <= sign2_s;
            cnt_r   <= 5'd0;
            dbz_r   <= special_dbz_s;
            if (bus.op[2]) begin
              mag_r <= abs2_s;
              acc_r <= {32'd0, abs1_s};
            end else begin
              mag_r <= abs1_s;
              acc_r <= {32'd0, abs2_s};
            end
            if (special_s) begin
              result_r <= special_res_s;
              state_r  <= DONE;
            end else begin
              state_r  <= BUSY;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          acc_r <= op_r[2] ? div_next_s : mul_next_s;
          cnt_r <= cnt_r + 5'd1;
          if (cnt_r == 5'd31) begin
            state_r <= FIX;
          end else begin
            state_r <= BUSY;
          end
        end
        FIX: begin
          result_r <= fix_res_s;
          state_r  <= DONE;
        end
        DONE: begin
          if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed self-checking bench for muldiv_unit against an arithmetic model.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;

  muldiv_unit_if bus();

  muldiv_unit dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: RISC-V M semantics using wide arithmetic. Returns {div_by_zero, result}.
  function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      p;
    logic [63:0] u;
    int          sa, sb;
    sa = a;
    sb = b;
    case (op)
      3'd0: begin p = longint'(sa) * longint'(sb); return {1'b0, p[31:0]}; end
      3'd1: begin p = longint'(sa) * longint'(sb); return {1'b0, p[63:32]}; end
      3'd2: begin p = longint'(sa) * longint'({32'd0, b}); return {1'b0, p[63:32]}; end
      3'd3: begin u = {32'd0, a} * {32'd0, b}; return {1'b0, u[63:32]}; end
      3'd4: begin
        if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h8000_0000};
        return {1'b0, 32'(sa / sb)};
      end
      3'd5: begin
        if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF};
        return {1'b0, a / b};
      end
      3'd6: begin
        if (b == 32'd0) return {1'b1, a};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0};
        return {1'b0, 32'(sa % sb)};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a};
        return {1'b0, a % b};
      end
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 32'd0) return 1;
    if (op[2] && !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Called #1 after the accepting edge: waits for the result, checks it, then drains.
  task automatic collect(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int stall);
    logic [32:0] exp;
    int cycles = 0;
    exp = model(op, a, b);
    while (bus.out_valid !== 1'b1 && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
    end
    chk($sformatf("latency op%0d", op), 32'(cycles), 32'(exp_latency(op, a, b)));
    chk($sformatf("result op%0d %h,%h", op, a, b), bus.result, exp[31:0]);
    chk($sformatf("dbz op%0d", op), {31'd0, bus.div_by_zero}, {31'd0, exp[32]});
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall result", bus.result, exp[31:0]);
      chk("stall in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("stall out_valid", {31'd0, bus.out_valid}, 32'd1);
    end
    @(negedge clk); bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("drain out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("drain in_ready", {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = op; bus.operand1 = a; bus.operand2 = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit scramble, input int stall);
    issue(op, a, b);
    if (scramble) begin
      bus.operand1 = $urandom; bus.operand2 = $urandom; bus.op = 3'($urandom);
    end
    collect(op, a, b, stall);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int seen;
    logic [31:0] held;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.op = 3'd0; bus.operand1 = 32'd0; bus.operand2 = 32'd0;
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset result", bus.result, 32'd0);
    chk("reset dbz", {31'd0, bus.div_by_zero}, 32'd0);
    @(negedge clk); rst = 1'b0;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
    run_op(3'd5, 32'd100, 32'd7, 1'b0, 0);
    run_op(3'd7, 32'd100, 32'd7, 1'b0, 0);
    run_op(3'd5, 32'd1234, 32'd0, 1'b0, 0);
    run_op(3'd6, 32'd1234, 32'd0, 1'b0, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    run_op(3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 0);

    // Backpressure with a pending request held during the stall.
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    seen = 0;
    while (bus.out_valid !== 1'b1 && seen < 100) begin
      @(posedge clk); #1; seen++;
    end
    chk("bp latency", 32'(seen), 32'd34);
    bus.in_valid = 1'b1; bus.op = 3'd5; bus.operand1 = 32'd100; bus.operand2 = 32'd7;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp result", bus.result, 32'hFFFF_FFFE);
      chk("bp in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    @(negedge clk); bus.out_ready = 1'b1;
    @(posedge clk); #1; bus.out_ready = 1'b0;
    chk("bp idle after handshake", {31'd0, bus.in_ready}, 32'd1);
    chk("bp out_valid dropped", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk); #1; bus.in_valid = 1'b0;
    chk("bp pending accepted", {31'd0, bus.in_ready}, 32'd0);
    collect(3'd5, 32'd100, 32'd7, 0);

    // Flush mid-BUSY.
    held = bus.result;
    issue(3'd0, 32'd12345, 32'd678);
    repeat (10) @(posedge clk);
    @(negedge clk); bus.flush = 1'b1;
    @(posedge clk); #1; bus.flush = 1'b0;
    chk("flush in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("flush out_valid", {31'd0, bus.out_valid}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    chk("flush no result", 32'(seen), 32'd0);
    chk("flush result held", bus.result, held);

    // Reset mid-BUSY.
    issue(3'd4, 32'h7654_3210, 32'd3);
    repeat (20) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rst result", bus.result, 32'd0);
    chk("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 60; i++) begin
      run_op(3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
